bit_stuff_serializer: RTL and testbench
=======================================

BIT_STUFF_SERIALIZER -- requirements
Module: bit_stuff_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, parallel byte width in bits.
REQ-002 SHALL have parameter RUN_LEN, default 5, count of consecutive 1s after which a 0 is stuffed.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state SHALL change on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port dataIn, input, DATA_W bits, the parallel word to serialize.
REQ-006 SHALL have port inValid, input, 1 bit, high when dataIn holds a word to send.
REQ-007 SHALL have port inReady, output, 1 bit, high when the block accepts dataIn at the next rising edge.
REQ-008 SHALL have port serOut, output, 1 bit, the serial stream that feeds the downstream serIn.
REQ-009 SHALL have port serValid, output, 1 bit, high in every cycle in which serOut carries a data or stuff bit.

Function
REQ-010 SHALL implement an FSM with states IDLE, SHIFT and STUFF.
REQ-011 SHALL accept a word on a rising edge where inValid and inReady are both high; acceptance SHALL load the shift register, set bitCnt to 0 and move to SHIFT.
REQ-012 SHALL drive serOut as shiftReg[0] (LSB first) in SHIFT, 0 in STUFF and 0 in IDLE, and drive serValid = (state != IDLE).
REQ-013 SHALL present the first bit of an accepted word in the cycle right after the accepting edge, giving 1 cycle of latency.
REQ-014 SHALL, in SHIFT, shift right by one and increment bitCnt on each edge.
REQ-015 SHALL keep onesCnt (width clog2(RUN_LEN+1)): increment on each emitted data 1, clear on each emitted 0 (data or stuff).
REQ-016 SHALL go from SHIFT to STUFF on the edge that ends a data-1 cycle in which onesCnt == RUN_LEN-1.
REQ-017 SHALL spend exactly one cycle in STUFF, then go to SHIFT if bits remain, otherwise take the end-of-word action.
REQ-018 SHALL assert inReady (combinational) in IDLE, in SHIFT on the last data bit (bitCnt == DATA_W-1) when that bit does not trigger a stuff, and in STUFF when no data bits remain.
REQ-019 SHALL apply this end-of-word action: if inValid is high, accept the next word back-to-back with no gap cycle; otherwise go to IDLE.
REQ-020 SHALL carry onesCnt across back-to-back words and clear it on entry to IDLE.
REQ-021 SHALL never emit more than RUN_LEN consecutive 1s on serOut while serValid is high.
REQ-022 SHALL ignore dataIn and inValid while inReady is low; no word SHALL be lost or duplicated.

Reset
REQ-023 SHALL, while rst is high, force state to IDLE, shiftReg, bitCnt and onesCnt to 0, serOut and serValid to 0, and inReady to 1, regardless of clk.
REQ-024 SHALL discard any partially sent word when reset occurs mid-word; after reset deasserts, the next accepted word SHALL start fresh with onesCnt = 0.

Structure
REQ-025 SHALL take the state enum typedef (IDLE/SHIFT/STUFF) and default constants DATA_W_DEF=8 and RUN_LEN_DEF=5 from the shared package bit_stuff_pkg.
REQ-026 SHALL put the onesCnt logic in one sub-module, ones_run_counter (inputs clk, rst, bitValid, bitVal, clear; output runDone).
REQ-027 SHALL remain in one clock domain with no latches; every FSM case SHALL have a default that returns to IDLE.

Verification
REQ-028 Single 0x00 -> serValid high for 8 cycles, serOut = 00000000, then IDLE.
REQ-029 Single 0xFF -> 9 cycles, serOut = 11111 0 111, inReady high in the 9th cycle, then IDLE with onesCnt = 0.
REQ-030 0xFF, 0xFF back-to-back with inValid held -> 19 contiguous serValid cycles, serOut = 11111 0 11111 0 11111 0 1, no gap between the words.
REQ-031 Single 0x3E -> serOut = 0 11111 0 0 0 (9 bits); feeding this into the downstream detector SHALL raise its output on the stuffed 0.
REQ-032 rst pulsed for 2 cycles after the 3rd bit of 0xFF -> serValid and serOut drop to 0 immediately without a clock edge; next word 0x01 -> serOut = 10000000 with no stuff.
REQ-033 inValid high with dataIn changing every cycle while busy -> only the values present on inReady-high edges are serialized, in order, each exactly once.

Source files
------------

// File: rtl/bit_stuff_pkg.sv
// bit_stuff_pkg: shared FSM state type and default sizing for the bit-stuffing serializer
package bit_stuff_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, STUFF} state_t;
  localparam int DATA_W_DEF = 8;
  localparam int RUN_LEN_DEF = 5;
endpackage

// File: rtl/ones_run_counter.sv
// ones_run_counter: tracks the current run of emitted 1s and flags the bit that completes a full run
module ones_run_counter import bit_stuff_pkg::*; #(
  parameter int RUN_LEN = RUN_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic bitValid,
  input  logic bitVal,
  input  logic clear,
  output logic runDone
);
  localparam int W = $clog2(RUN_LEN + 1);
  logic [W-1:0] cnt;
  assign runDone = bitValid & bitVal & (cnt == W'(RUN_LEN - 1));
  // count emitted 1s, any emitted 0 (data or stuff) or an IDLE entry restarts the run
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clear) cnt <= '0;
    else if (bitValid) cnt <= bitVal ? cnt + W'(1) : '0;
endmodule

// File: rtl/bit_stuff_serializer.sv
// bit_stuff_serializer: LSB-first word serializer that stuffs a 0 after every RUN_LEN consecutive 1s
module bit_stuff_serializer import bit_stuff_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RUN_LEN = RUN_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] dataIn,
  input  logic              inValid,
  output logic              inReady,
  output logic              serOut,
  output logic              serValid
);
  localparam int CW = $clog2(DATA_W + 1);
  state_t state, state_next;
  logic [DATA_W-1:0] shift_reg;
  logic [CW-1:0] bit_cnt;
  logic data_bit, run_done, last, remain, accept;
  assign data_bit = (state == SHIFT) & shift_reg[0];
  assign last = bit_cnt == CW'(DATA_W - 1);
  assign remain = bit_cnt != CW'(DATA_W);
  assign accept = inValid & inReady;
  ones_run_counter #(.RUN_LEN(RUN_LEN)) u_ones (
    .clk(clk),
    .rst(rst),
    .bitValid(state != IDLE),
    .bitVal(data_bit),
    .clear(state_next == IDLE),
    .runDone(run_done)
  );
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_next;
  // next state: a finished word either chains straight into the next one or drops to IDLE
  always_comb begin
    state_next = IDLE;
    case (state)
      IDLE:  state_next = accept ? SHIFT : IDLE;
      SHIFT: state_next = run_done ? STUFF : (last & ~inValid) ? IDLE : SHIFT;
      STUFF: state_next = (remain | inValid) ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end
  // outputs: ready only where the current cycle closes out a word
  always_comb begin
    serOut = data_bit;
    serValid = state != IDLE;
    inReady = (state == IDLE) | ((state == SHIFT) & last & ~run_done) | ((state == STUFF) & ~remain);
  end
  // shift register and data bit counter; a new word overrides the final shift
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      shift_reg <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      shift_reg <= dataIn;
      bit_cnt <= '0;
    end else if (state == SHIFT) begin
      shift_reg <= shift_reg >> 1;
      bit_cnt <= bit_cnt + CW'(1);
    end
endmodule

// File: tb/tb_bit_stuff_serializer.sv
// tb_bit_stuff_serializer: directed vector bench for the bit-stuffing serializer
module tb_bit_stuff_serializer;
  logic clk, rst, inValid, inReady, serOut, serValid;
  logic [7:0] dataIn;
  int checks = 0;
  int fails = 0;

  bit_stuff_serializer #(.DATA_W(8), .RUN_LEN(5)) dut (
    .clk(clk), .rst(rst), .dataIn(dataIn), .inValid(inValid),
    .inReady(inReady), .serOut(serOut), .serValid(serValid)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [23:0] words;
    int          nw;
    logic [31:0] exp;
    int          n;
  } vec_t;
  vec_t tbl[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // sends nw words (low byte first); while busy, inValid is held high with junk data
  task automatic run_words(input logic [23:0] words, input int nw, output logic [31:0] got,
                           output int n, output logic last_ready, output logic idle_ok);
    int idx = 0;
    bit started = 0;
    got = 0; n = 0; last_ready = 0; idle_ok = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (serValid) begin
        started = 1;
        if (n < 32) got[n] = serOut;
        n++;
        last_ready = inReady;
      end else if (started) begin
        idle_ok = inReady;
        break;
      end
      if (idx < nw) begin
        inValid = 1;
        if (inReady) begin
          dataIn = words[idx*8 +: 8];
          idx++;
        end else dataIn = 8'($urandom);
      end else begin
        inValid = !inReady;
        dataIn = 8'($urandom);
      end
    end
    inValid = 0;
  endtask

  logic [31:0] got;
  int n, run, fire;
  logic lr, ok;

  initial begin
    tbl[0] = '{24'h00, 1, 32'h0, 8};
    tbl[1] = '{24'hFF, 1, 32'h1DF, 9};
    tbl[2] = '{24'h3E, 1, 32'h03E, 9};
    tbl[3] = '{24'hAA, 1, 32'hAA, 8};
    tbl[4] = '{24'h1F, 1, 32'h1F, 9};
    tbl[5] = '{24'hF8, 1, 32'hF8, 9};
    tbl[6] = '{24'h7F, 1, 32'hDF, 9};
    tbl[7] = '{24'hFFFF, 2, 32'h5F7DF, 19};
    tbl[8] = '{24'h03F0, 2, 32'h5F0, 17};
    tbl[9] = '{24'h55810F, 3, 32'h55810F, 24};
    rst = 1; inValid = 0; dataIn = 0;
    #2;
    chk("reset serValid", {31'b0, serValid}, 0);
    chk("reset serOut", {31'b0, serOut}, 0);
    chk("reset inReady", {31'b0, inReady}, 1);
    @(negedge clk); @(negedge clk);
    rst = 0;
    for (int i = 0; i < 10; i++) begin
      run_words(tbl[i].words, tbl[i].nw, got, n, lr, ok);
      chk($sformatf("vec%0d stream", i), got, tbl[i].exp);
      chk($sformatf("vec%0d length", i), n, tbl[i].n);
      chk($sformatf("vec%0d idle ready", i), {31'b0, ok}, 1);
    end
    run_words(24'hFF, 1, got, n, lr, ok);
    chk("FF ready in last cycle", {31'b0, lr}, 1);
    run_words(24'h3E, 1, got, n, lr, ok);
    run = 0; fire = -1;
    for (int i = 0; i < n && i < 32; i++) begin
      if (got[i]) run++;
      else begin
        if (run == 5 && fire < 0) fire = i;
        run = 0;
      end
    end
    chk("3E detector fires on stuff", fire, 6);
    @(negedge clk);
    dataIn = 8'hFF; inValid = 1;
    @(posedge clk); #1 inValid = 0;
    @(negedge clk); @(negedge clk); @(negedge clk);
    chk("mid-word 3rd bit", {30'b0, serValid, serOut}, 3);
    rst = 1;
    #1;
    chk("async reset serValid/serOut", {30'b0, serValid, serOut}, 0);
    chk("async reset inReady", {31'b0, inReady}, 1);
    @(negedge clk); @(negedge clk);
    rst = 0;
    run_words(24'h01, 1, got, n, lr, ok);
    chk("after reset 01 stream", got, 32'h01);
    chk("after reset 01 length", n, 8);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
